// File: rtl/crc_stream.sv
// crc_stream: byte-serial CRC engine with a framed valid/ready input
// and a held result that waits for the consumer.
module crc_stream #(
  parameter int               WIDTH  = 16,
  parameter logic [WIDTH-1:0] POLY   = 16'h1021,
  parameter logic [WIDTH-1:0] INIT   = '0,
  parameter bit               REFIN  = 1'b0,
  parameter bit               REFOUT = 1'b0,
  parameter logic [WIDTH-1:0] XOROUT = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [7:0]       in_data,
  input  logic             in_valid,
  input  logic             in_last,
  output logic             in_ready,
  output logic [WIDTH-1:0] out_crc,
  output logic [15:0]      out_len,
  output logic             out_valid,
  input  logic             out_ready
);

  typedef enum logic {
    ACCUM = 1'b0,
    DONE  = 1'b1
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] crc_q, crc_d;
  logic [15:0]      cnt_q, cnt_d;
  logic [WIDTH-1:0] ocrc_q, ocrc_d;
  logic [15:0]      olen_q, olen_d;
  logic             oval_q, oval_d;

  logic             accept;
  logic [7:0]       byte_in;
  logic [WIDTH-1:0] crc_nxt;
  logic [WIDTH-1:0] crc_fin;
  logic [15:0]      cnt_inc;

  function automatic logic [7:0] rev8(
    input logic [7:0] b
  );
    logic [7:0] r;
    for (int i = 0; i < 8; i++)
      r[i] = b[7-i];
    return r;
  endfunction

  function automatic logic [WIDTH-1:0] revw(
    input logic [WIDTH-1:0] v
  );
    logic [WIDTH-1:0] r;
    for (int i = 0; i < WIDTH; i++)
      r[i] = v[WIDTH-1-i];
    return r;
  endfunction

  // Byte enters at the top of the register, then eight MSB-first steps.
  function automatic logic [WIDTH-1:0] crc_byte(
    input logic [WIDTH-1:0] c,
    input logic [7:0]       b
  );
    logic [WIDTH-1:0] r;
    r = c ^ (WIDTH'(b) << (WIDTH - 8));
    for (int i = 0; i < 8; i++) begin
      if (r[WIDTH-1])
        r = (r << 1) ^ POLY;
      else
        r = r << 1;
    end
    return r;
  endfunction

  assign in_ready  = (state_q == ACCUM);
  assign out_crc   = ocrc_q;
  assign out_len   = olen_q;
  assign out_valid = oval_q;

  assign accept  = in_valid && in_ready;
  assign byte_in = REFIN ? rev8(in_data) : in_data;
  assign crc_nxt = crc_byte(crc_q, byte_in);
  assign crc_fin = (REFOUT ? revw(crc_nxt) : crc_nxt) ^ XOROUT;
  assign cnt_inc = (cnt_q == 16'hFFFF) ? cnt_q : cnt_q + 16'd1;

  always_comb begin
    state_d = state_q;
    crc_d   = crc_q;
    cnt_d   = cnt_q;
    ocrc_d  = ocrc_q;
    olen_d  = olen_q;
    oval_d  = oval_q;
    unique case (1'b1)
      (state_q == ACCUM): begin
        if (accept) begin
          crc_d = crc_nxt;
          cnt_d = cnt_inc;
          if (in_last) begin
            ocrc_d  = crc_fin;
            olen_d  = cnt_inc;
            oval_d  = 1'b1;
            state_d = DONE;
          end
        end
      end
      (state_q == DONE): begin
        if (oval_q && out_ready) begin
          oval_d  = 1'b0;
          crc_d   = INIT;
          cnt_d   = 16'd0;
          state_d = ACCUM;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ACCUM;
      crc_q   <= INIT;
      cnt_q   <= 16'd0;
      ocrc_q  <= '0;
      olen_q  <= 16'd0;
      oval_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      crc_q   <= crc_d;
      cnt_q   <= cnt_d;
      ocrc_q  <= ocrc_d;
      olen_q  <= olen_d;
      oval_q  <= oval_d;
    end
  end

endmodule

// File: tb/tb_crc_stream.sv
// tb_crc_stream: four crc_stream configurations fed the same stream,
// checked against a bit-serial polynomial-division model.
module tb_crc_stream;

  logic        clk = 1'b0;
  logic        reset;
  logic [7:0]  in_data;
  logic        in_valid;
  logic        in_last;
  logic        out_ready;

  logic        rdy8, rdy16, rdy16i, rdy32;
  logic [7:0]  crc8;
  logic [15:0] crc16, crc16i;
  logic [31:0] crc32;
  logic [15:0] len8, len16, len16i, len32;
  logic        ov8, ov16, ov16i, ov32;

  int n_chk = 0;
  int n_bad = 0;
  byte unsigned msg[$];

  always #5 clk = ~clk;

  crc_stream #(
    .WIDTH(8), .POLY(8'h07), .INIT(8'h00),
    .REFIN(1'b0), .REFOUT(1'b0), .XOROUT(8'h00)
  ) u_d8 (
    .clk(clk), .reset(reset), .in_data(in_data),
    .in_valid(in_valid), .in_last(in_last), .in_ready(rdy8),
    .out_crc(crc8), .out_len(len8), .out_valid(ov8),
    .out_ready(out_ready)
  );

  crc_stream u_d16 (
    .clk(clk), .reset(reset), .in_data(in_data),
    .in_valid(in_valid), .in_last(in_last), .in_ready(rdy16),
    .out_crc(crc16), .out_len(len16), .out_valid(ov16),
    .out_ready(out_ready)
  );

  crc_stream #(
    .INIT(16'hFFFF)
  ) u_d16i (
    .clk(clk), .reset(reset), .in_data(in_data),
    .in_valid(in_valid), .in_last(in_last), .in_ready(rdy16i),
    .out_crc(crc16i), .out_len(len16i), .out_valid(ov16i),
    .out_ready(out_ready)
  );

  crc_stream #(
    .WIDTH(32), .POLY(32'h04C11DB7), .INIT(32'hFFFFFFFF),
    .REFIN(1'b1), .REFOUT(1'b1), .XOROUT(32'hFFFFFFFF)
  ) u_d32 (
    .clk(clk), .reset(reset), .in_data(in_data),
    .in_valid(in_valid), .in_last(in_last), .in_ready(rdy32),
    .out_crc(crc32), .out_len(len32), .out_valid(ov32),
    .out_ready(out_ready)
  );

  task automatic chk(
    input string       tag,
    input logic [31:0] got,
    input logic [31:0] exp
  );
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] ref_crc(
    input int          w,
    input logic [31:0] poly,
    input logic [31:0] init,
    input bit          refin,
    input bit          refout,
    input logic [31:0] xorout
  );
    logic [31:0] mask, c, r;
    logic        bv, fb;
    mask = (w == 32) ? 32'hFFFFFFFF : ((32'h1 << w) - 32'h1);
    c = init & mask;
    foreach (msg[i]) begin
      for (int k = 0; k < 8; k++) begin
        bv = refin ? msg[i][k] : msg[i][7-k];
        fb = c[w-1] ^ bv;
        c  = (c << 1) & mask;
        if (fb) c = c ^ (poly & mask);
      end
    end
    if (refout) begin
      r = '0;
      for (int j = 0; j < w; j++) r[j] = c[w-1-j];
      c = r;
    end
    return (c ^ xorout) & mask;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load_str();
    msg = {};
    for (int i = 0; i < 9; i++) msg.push_back(8'h31 + i[7:0]);
  endtask

  task automatic send_msg(input int gap, input int n);
    int i   = 0;
    int cyc = 0;
    bit acc;
    while (i < n && cyc < 2000) begin
      if (gap > 0 && $urandom_range(99) < gap) begin
        in_valid = 1'b0;
        in_data  = 8'($urandom);
        in_last  = $urandom_range(1);
      end else begin
        in_valid = 1'b1;
        in_data  = msg[i];
        in_last  = (i == msg.size() - 1);
      end
      acc = in_valid && rdy16;
      tick();
      cyc++;
      if (acc) i++;
    end
    if (cyc >= 2000) chk("send_timeout", 1, 0);
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic check_result(input string tag);
    chk({tag, "_ov16"}, 32'(ov16), 1);
    chk({tag, "_ov8"}, 32'(ov8 & ov16i & ov32), 1);
    chk({tag, "_len"}, 32'(len16), msg.size());
    chk({tag, "_len32"}, 32'(len32), msg.size());
    chk({tag, "_c8"}, 32'(crc8), ref_crc(8, 32'h07, 0, 0, 0, 0));
    chk({tag, "_c16"}, 32'(crc16), ref_crc(16, 32'h1021, 0, 0, 0, 0));
    chk({tag, "_c16i"}, 32'(crc16i),
        ref_crc(16, 32'h1021, 32'hFFFF, 0, 0, 0));
    chk({tag, "_c32"}, crc32,
        ref_crc(32, 32'h04C11DB7, 32'hFFFFFFFF, 1, 1, 32'hFFFFFFFF));
  endtask

  task automatic consume(input string tag);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk({tag, "_ovclr"}, 32'(ov16 | ov32), 0);
    chk({tag, "_rdy"}, 32'(rdy16 & rdy8), 1);
  endtask

  initial begin
    logic [15:0] held;
    int          len;
    int          wt;
    reset     = 1'b1;
    in_data   = 8'h00;
    in_valid  = 1'b0;
    in_last   = 1'b0;
    out_ready = 1'b0;
    tick();
    tick();
    reset = 1'b0;
    chk("rst_rdy", 32'(rdy16), 1);
    chk("rst_ov", 32'(ov16 | ov8 | ov32), 0);
    chk("rst_crc", 32'(crc16) | crc32, 0);
    chk("rst_len", 32'(len16), 0);

    load_str();
    out_ready = 1'b1;
    send_msg(0, msg.size());
    chk("chk_f4", 32'(crc8), 32'hF4);
    chk("chk_31c3", 32'(crc16), 32'h31C3);
    chk("chk_29b1", 32'(crc16i), 32'h29B1);
    chk("chk_cbf4", crc32, 32'hCBF43926);
    check_result("std");
    tick();
    out_ready = 1'b0;
    chk("std_ovclr", 32'(ov16), 0);

    msg = {8'h31};
    send_msg(0, 1);
    chk("one_97", 32'(crc8), 32'h97);
    chk("one_len", 32'(len8), 1);
    check_result("one");
    consume("one");

    load_str();
    send_msg(30, msg.size());
    check_result("bp");
    held = crc16;
    for (int c = 0; c < 5; c++) begin
      in_valid = 1'b1;
      in_last  = 1'b1;
      in_data  = 8'($urandom);
      tick();
      chk("bp_rdy", 32'(rdy16), 0);
      chk("bp_ov", 32'(ov16), 1);
      chk("bp_hold", 32'(crc16), 32'(held));
    end
    in_valid = 1'b0;
    consume("bp");
    msg = {8'hA5, 8'h00, 8'hFF};
    send_msg(0, msg.size());
    check_result("bp2");
    consume("bp2");

    load_str();
    send_msg(0, 4);
    chk("ab_ov", 32'(ov16), 0);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("ab_rdy", 32'(rdy16), 1);
    chk("ab_ov2", 32'(ov16 | ov32), 0);
    send_msg(0, msg.size());
    chk("ab_31c3", 32'(crc16), 32'h31C3);
    check_result("ab");
    consume("ab");

    for (int f = 0; f < 25; f++) begin
      len = $urandom_range(20, 1);
      msg = {};
      for (int i = 0; i < len; i++) msg.push_back(8'($urandom));
      send_msg(40, len);
      check_result("rnd");
      held = crc16;
      wt = $urandom_range(3);
      for (int c = 0; c < wt; c++) tick();
      chk("rnd_hold", 32'(crc16), 32'(held));
      consume("rnd");
    end

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule

// File: doc/crc_stream.md
CRC_STREAM -- requirements
Module: crc_stream

Interface
REQ-001 Parameter WIDTH, default 16: CRC register width in bits; legal range 8..32.
REQ-002 Parameter POLY, default 16'h1021: generator polynomial, implicit top bit omitted, WIDTH bits.
REQ-003 Parameter INIT, default 0: CRC register value at the start of every frame.
REQ-004 Parameter REFIN, default 0: when 1, each input byte is bit-reversed before processing.
REQ-005 Parameter REFOUT, default 0: when 1, the final CRC is bit-reversed across WIDTH bits.
REQ-006 Parameter XOROUT, default 0: value XORed into the final CRC after any REFOUT reversal.
REQ-007 clk  input  1  single clock; all state updates on its rising edge.
REQ-008 reset  input  1  synchronous, active-high reset.
REQ-009 in_data  input  8  message byte.
REQ-010 in_valid  input  1  in_data/in_last are valid.
REQ-011 in_last  input  1  current byte is the final byte of the frame.
REQ-012 in_ready  output  1  block accepts a byte this cycle.
REQ-013 out_crc  output  WIDTH  final CRC of the completed frame.
REQ-014 out_len  output  16  byte count of the completed frame.
REQ-015 out_valid  output  1  out_crc/out_len hold a completed result.
REQ-016 out_ready  input  1  consumer accepts the result.

Function
REQ-017 The block SHALL implement a two-state FSM: ACCUM (accepting bytes) and DONE (holding a result).
REQ-018 in_ready SHALL equal 1 in ACCUM and 0 in DONE, decoded from the state register only, with no combinational path from any input.
REQ-019 A byte SHALL be accepted on any rising edge where in_valid && in_ready; no byte is accepted otherwise.
REQ-020 Each accepted byte SHALL be processed in one cycle.
  - Processing is 8 MSB-first shift/XOR steps of POLY, applied to the running register crc_q with the byte aligned to its top 8 bits.
  - The byte is bit-reversed first when REFIN=1.
REQ-021 crc_q SHALL be loaded with INIT on reset and on every DONE->ACCUM transition.
REQ-022 A 16-bit byte counter SHALL increment per accepted byte and saturate at 16'hFFFF; it SHALL be cleared whenever crc_q is loaded with INIT.
REQ-023 On an accepted byte with in_last=1, the edge SHALL perform the following, and the FSM SHALL enter DONE:
  - register out_crc = (REFOUT ? reverse(crc_next) : crc_next) ^ XOROUT;
  - register out_len = count including this byte;
  - set out_valid=1.
  Result latency SHALL be 1 cycle after the last byte is accepted.
REQ-024 In DONE, out_crc, out_len and out_valid SHALL stay stable until out_valid && out_ready.
REQ-025 On out_valid && out_ready, the FSM SHALL return to ACCUM, clear out_valid, and reload crc_q and the counter; the first byte of the next frame is accepted no earlier than the following cycle.
REQ-026 A single-byte frame (in_last on the first byte) SHALL be legal and produce a correct CRC with out_len=1.
REQ-027 in_valid with in_ready=0 SHALL have no effect; inputs are don't-care when in_valid=0.
REQ-028 A zero-length frame SHALL be impossible: out_valid is only set by an accepted byte with in_last=1.
REQ-029 All arithmetic SHALL be exactly WIDTH bits; no bit of crc_q at or above WIDTH exists.

Reset
REQ-030 When reset=1 at a rising edge, regardless of state or frame progress, the block SHALL enter ACCUM with:
  - crc_q=INIT, counter=0;
  - out_valid=0, out_crc=0, out_len=0.
REQ-031 During the cycle after reset is released, in_ready SHALL be 1; a partially received frame is discarded with no output.

Verification
REQ-032 WIDTH=8, POLY=8'h07, others 0; bytes "123456789", last on '9', out_ready=1 -> out_crc=8'hF4, out_len=9, one cycle after '9' is accepted.
REQ-033 Defaults (CRC-16/XMODEM), same stream -> out_crc=16'h31C3; then with INIT=16'hFFFF -> out_crc=16'h29B1.
REQ-034 WIDTH=32, POLY=32'h04C11DB7, INIT=XOROUT=32'hFFFFFFFF, REFIN=REFOUT=1, same stream -> out_crc=32'hCBF43926.
REQ-035 Backpressure: out_ready=0 for 5 cycles after the result with in_valid held 1 -> in_ready=0 and out_crc stable throughout; the second frame computes its own correct CRC after out_ready rises.
REQ-036 Assert reset after 4 bytes of "123456789", then send the full string -> no out_valid from the aborted frame; second result out_crc=16'h31C3 (defaults).
REQ-037 Single byte 8'h31 with in_last, WIDTH=8, POLY=8'h07 -> out_crc=8'h97, out_len=1; random in_valid gaps inside a frame do not change any result.
